// File: rtl/branch_hazard_pkg.sv
// Package: branch_hazard_pkg
// Shared definitions for the ID-stage branch hazard controller and the
// operand forwarding logic that sits beside it.
//   CP0_MFC0      CP0 op code for mfc0 (writes rw with load-like latency)
//   LOAD_LAT_DEF  default cycles from issue until a load/mfc0 result is
//                 forwardable from the WR stage
//   fwd_sel_e     forwarding mux select encodings used by the forwarding unit
//   is_load_like  true for instructions whose result arrives late (load, mfc0)
package branch_hazard_pkg;

  localparam logic [2:0] CP0_MFC0     = 3'b001;
  localparam int         LOAD_LAT_DEF = 2;

  // Forwarding source encodings; priority in the forwarding unit is EX > MEM > WR,
  // which is why the scoreboard lets the youngest write win.
  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_EX   = 2'b01,
    FWD_MEM  = 2'b10,
    FWD_WR   = 2'b11
  } fwd_sel_e;

  // Loads and mfc0 cannot be forwarded until they reach WR.
  function automatic logic is_load_like(input logic memtoreg, input logic [2:0] cp0op);
    return memtoreg | (cp0op == CP0_MFC0);
  endfunction

endpackage

// File: rtl/hazard_sb_cell.sv
// Module: hazard_sb_cell
// One scoreboard entry: counts the cycles remaining until the pending write to
// this register becomes forwardable.
// Ports:
//   clk       in  pipeline clock, rising edge
//   rst       in  asynchronous active-high reset
//   clear     in  flush all in-flight writes (highest priority after reset)
//   load      in  a new write to this register issues this cycle
//   load_val  in  count to load (LOAD_LAT for load/mfc0, 0 for ALU writes)
//   cnt       out current count, 0 = forwardable or nothing pending
module hazard_sb_cell #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt
);

  // A newly issued write overrides any older pending count (youngest wins);
  // otherwise the count drains by one every cycle, stalled or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Module: branch_hazard_ctrl
// Producer-side companion to ID-stage branch operand forwarding. Tracks
// in-flight results that forwarding cannot deliver yet (loads, mfc0) in a
// per-register scoreboard and stalls ID until its operands are forwardable.
// Optional feature macro: BRANCH_STALL_PERF_EN adds the stall_cycles counter.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   id_valid        ID holds a live instruction
//   id_is_branch    ID instruction compares operands in ID
//   id_rs, id_rt    source register indices; id_use_rs/id_use_rt qualify them
//   id_regWr, id_rw register write enable and destination
//   id_memtoreg     ID instruction is a load
//   id_cp0op        CP0 op, mfc0 behaves like a load
//   flush_id        kill the ID instruction this cycle
//   flush_all       kill all in-flight writes
//   stall           hold PC and IF/ID
//   id_ex_bubble    insert a NOP into ID/EX
//   stall_cycles    count of stalled cycles (BRANCH_STALL_PERF_EN only)
module branch_hazard_ctrl
  import branch_hazard_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int LOAD_LAT = LOAD_LAT_DEF,
  parameter int CNT_W    = 2
`ifdef BRANCH_STALL_PERF_EN
  ,
  parameter int PERF_W   = 32
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic                    id_is_branch,
  input  logic [$clog2(NREG)-1:0] id_rs,
  input  logic [$clog2(NREG)-1:0] id_rt,
  input  logic                    id_use_rs,
  input  logic                    id_use_rt,
  input  logic                    id_regWr,
  input  logic [$clog2(NREG)-1:0] id_rw,
  input  logic                    id_memtoreg,
  input  logic [2:0]              id_cp0op,
  input  logic                    flush_id,
  input  logic                    flush_all,
  output logic                    stall,
  output logic                    id_ex_bubble
`ifdef BRANCH_STALL_PERF_EN
  ,
  output logic [PERF_W-1:0]       stall_cycles
`endif
);

  localparam int IDX_W = $clog2(NREG);
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LOAD_LAT);

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_rs;
  logic [CNT_W-1:0] cnt_rt;
  logic [CNT_W-1:0] load_val;
  logic             hz_rs;
  logic             hz_rt;
  logic             issue;
  logic             issue_wr;
  logic             is_writer;
  logic             is_long;

  // Register 0 never holds a pending value.
  assign cnt_q[0] = '0;

  // Decode what the ID instruction will do to the scoreboard if it issues.
  always_comb begin
    is_long   = is_load_like(id_memtoreg, id_cp0op);
    is_writer = id_regWr | (id_cp0op == CP0_MFC0);
    load_val  = is_long ? LAT_CNT : '0;
    issue     = id_valid & ~stall & ~flush_id & ~flush_all;
    issue_wr  = issue & is_writer & (id_rw != '0);
  end

  for (genvar r = 1; r < NREG; r++) begin : g_sb
    hazard_sb_cell #(
      .CNT_W(CNT_W)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .clear   (flush_all),
      .load    (issue_wr && (id_rw == IDX_W'(r))),
      .load_val(load_val),
      .cnt     (cnt_q[r])
    );
  end

  // Branches compare in ID, so they must wait until the value reaches WR
  // (count 0). Other instructions only need to skip the single cycle where
  // EX forwarding cannot reach the load, i.e. when the load is still in EX.
  always_comb begin
    cnt_rs = cnt_q[id_rs];
    cnt_rt = cnt_q[id_rt];
    hz_rs  = id_use_rs && (id_rs != '0) &&
             (id_is_branch ? (cnt_rs != '0) : (cnt_rs == LAT_CNT));
    hz_rt  = id_use_rt && (id_rt != '0) &&
             (id_is_branch ? (cnt_rt != '0) : (cnt_rt == LAT_CNT));
    stall        = id_valid & (hz_rs | hz_rt) & ~flush_id & ~flush_all;
    id_ex_bubble = stall;
  end

`ifdef BRANCH_STALL_PERF_EN
  // Stall-cycle counter; cleared only by reset, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall) begin
      stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Testbench: tb_branch_hazard_ctrl
// Directed vectors with hand-computed stall expectations for the branch
// hazard controller (LOAD_LAT = 2). Honors BRANCH_STALL_PERF_EN.
module tb_branch_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic       id_is_branch;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       id_regWr;
  logic [4:0] id_rw;
  logic       id_memtoreg;
  logic [2:0] id_cp0op;
  logic       flush_id;
  logic       flush_all;
  logic       stall;
  logic       id_ex_bubble;
`ifdef BRANCH_STALL_PERF_EN
  logic [31:0] stall_cycles;
`endif

  int n_vec;
  int n_miss;

  branch_hazard_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_is_branch(id_is_branch),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_regWr    (id_regWr),
    .id_rw       (id_rw),
    .id_memtoreg (id_memtoreg),
    .id_cp0op    (id_cp0op),
    .flush_id    (flush_id),
    .flush_all   (flush_all),
    .stall       (stall),
    .id_ex_bubble(id_ex_bubble)
`ifdef BRANCH_STALL_PERF_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives the whole ID-side input bundle.
  task automatic applyStimulus(input logic v, input logic br,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt,
                               input logic wr, input logic [4:0] rw,
                               input logic mem, input logic [2:0] cp0,
                               input logic fid, input logic fall);
    id_valid     = v;
    id_is_branch = br;
    id_rs        = rs;
    id_rt        = rt;
    id_use_rs    = urs;
    id_use_rt    = urt;
    id_regWr     = wr;
    id_rw        = rw;
    id_memtoreg  = mem;
    id_cp0op     = cp0;
    flush_id     = fid;
    flush_all    = fall;
  endtask

  // Compares stall and bubble against the hand-computed value.
  task automatic checkOutput(input string tag, input logic exp_stall);
    n_vec++;
    assert (stall === exp_stall) else begin
      n_miss++;
      $error("[TB] FAIL %s stall actual=%0b expected=%0b", tag, stall, exp_stall);
    end
    n_vec++;
    assert (id_ex_bubble === exp_stall) else begin
      n_miss++;
      $error("[TB] FAIL %s bubble actual=%0b expected=%0b", tag, id_ex_bubble, exp_stall);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doIdle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
  endtask

  task automatic doLoad(input logic [4:0] rd);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, rd, 1, 3'b000, 0, 0);
  endtask

  task automatic doMfc0(input logic [4:0] rd);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, rd, 0, 3'b001, 0, 0);
  endtask

  task automatic doBranch(input logic [4:0] rs, input logic [4:0] rt);
    applyStimulus(1, 1, rs, rt, 1, 1, 0, 0, 0, 3'b000, 0, 0);
  endtask

  task automatic doAlu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    applyStimulus(1, 0, rs, rt, 1, 1, 1, rd, 0, 3'b000, 0, 0);
  endtask

  // Two idle cycles drain any pending count back to zero.
  task automatic drain();
    nextCycle(); doIdle();
    nextCycle(); doIdle();
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst    = 1'b1;
    doIdle();
    #12;
    checkOutput("reset", 1'b0);
    rst = 1'b0;

    // lw r5; beq r5,r0 -> two stalls, issues on the third cycle
    nextCycle(); doLoad(5);      #2; checkOutput("lw_beq_lw", 1'b0);
    nextCycle(); doBranch(5, 0); #2; checkOutput("lw_beq_s1", 1'b1);
    nextCycle(); doBranch(5, 0); #2; checkOutput("lw_beq_s2", 1'b1);
    nextCycle(); doBranch(5, 0); #2; checkOutput("lw_beq_go", 1'b0);
    drain();

    // lw r5; nop; beq r5 -> one stall
    nextCycle(); doLoad(5);      #2; checkOutput("lw_nop_beq_lw", 1'b0);
    nextCycle(); doIdle();       #2; checkOutput("lw_nop_beq_nop", 1'b0);
    nextCycle(); doBranch(5, 0); #2; checkOutput("lw_nop_beq_s1", 1'b1);
    nextCycle(); doBranch(5, 0); #2; checkOutput("lw_nop_beq_go", 1'b0);
    drain();

    // lw r5; add r6,r5 -> classic load-use, one stall
    nextCycle(); doLoad(5);      #2; checkOutput("lw_add_lw", 1'b0);
    nextCycle(); doAlu(5, 0, 6); #2; checkOutput("lw_add_s1", 1'b1);
    nextCycle(); doAlu(5, 0, 6); #2; checkOutput("lw_add_go", 1'b0);
    drain();

    // lw r5; nop; add r6,r5 -> EX forwarding covers it, no stall
    nextCycle(); doLoad(5);      #2; checkOutput("lw_nop_add_lw", 1'b0);
    nextCycle(); doIdle();       #2; checkOutput("lw_nop_add_nop", 1'b0);
    nextCycle(); doAlu(5, 0, 6); #2; checkOutput("lw_nop_add_go", 1'b0);
    drain();

    // lw r5; add r5,r1,r2 (youngest ALU write); beq r5 -> no stall
    nextCycle(); doLoad(5);      #2; checkOutput("override_lw", 1'b0);
    nextCycle(); doAlu(1, 2, 5); #2; checkOutput("override_add", 1'b0);
    nextCycle(); doBranch(5, 0); #2; checkOutput("override_beq", 1'b0);
    drain();

    // mfc0 r7; bne r7 -> two stalls
    nextCycle(); doMfc0(7);      #2; checkOutput("mfc0_issue", 1'b0);
    nextCycle(); doBranch(0, 7); #2; checkOutput("mfc0_bne_s1", 1'b1);
    nextCycle(); doBranch(0, 7); #2; checkOutput("mfc0_bne_s2", 1'b1);
    nextCycle(); doBranch(0, 7); #2; checkOutput("mfc0_bne_go", 1'b0);
    drain();

    // lw r0; beq r0 -> never a hazard
    nextCycle(); doLoad(0);      #2; checkOutput("lw_r0", 1'b0);
    nextCycle(); doBranch(0, 0); #2; checkOutput("beq_r0", 1'b0);
    drain();

    // r5 pending but rs not used -> no stall
    nextCycle(); doLoad(5); #2; checkOutput("unused_lw", 1'b0);
    nextCycle();
    applyStimulus(1, 1, 5, 0, 0, 1, 0, 0, 0, 3'b000, 0, 0);
    #2; checkOutput("unused_rs", 1'b0);
    drain();

    // flush_all during a stall: stall drops now, scoreboard cleared next edge
    nextCycle(); doLoad(5);      #2; checkOutput("fa_lw", 1'b0);
    nextCycle(); doBranch(5, 0); #2; checkOutput("fa_pre", 1'b1);
    flush_all = 1'b1;            #1; checkOutput("fa_same", 1'b0);
    nextCycle(); doBranch(5, 0); #2; checkOutput("fa_after", 1'b0);
    drain();

    // flush_id on a load: no scoreboard update
    nextCycle(); doLoad(5); flush_id = 1'b1; #2; checkOutput("fid_lw", 1'b0);
    nextCycle(); doBranch(5, 0); #2; checkOutput("fid_beq", 1'b0);
    drain();

    // flush_id on a stalled branch: stall suppressed, count keeps draining
    nextCycle(); doLoad(5);      #2; checkOutput("fid2_lw", 1'b0);
    nextCycle(); doBranch(5, 0); flush_id = 1'b1; #2; checkOutput("fid2_kill", 1'b0);
    nextCycle(); doBranch(5, 0); #2; checkOutput("fid2_s1", 1'b1);
    nextCycle(); doBranch(5, 0); #2; checkOutput("fid2_go", 1'b0);
    drain();

    // rst pulse mid-stall: stall drops immediately, nothing left pending
    nextCycle(); doLoad(5);      #2; checkOutput("rst_lw", 1'b0);
    nextCycle(); doBranch(5, 0); #2; checkOutput("rst_pre", 1'b1);
    rst = 1'b1; #1; checkOutput("rst_same", 1'b0);
`ifdef BRANCH_STALL_PERF_EN
    n_vec++;
    assert (stall_cycles === 32'd0) else begin
      n_miss++;
      $error("[TB] FAIL perf_rst0 count actual=%0d expected=0", stall_cycles);
    end
`endif
    rst = 1'b0;
    nextCycle(); doBranch(5, 0); #2; checkOutput("rst_after", 1'b0);
    drain();

`ifdef BRANCH_STALL_PERF_EN
    // three stall cycles: two from lw/beq, one from lw/add
    nextCycle(); doLoad(5);      #2; checkOutput("perf_lw1", 1'b0);
    nextCycle(); doBranch(5, 0); #2; checkOutput("perf_s1", 1'b1);
    nextCycle(); doBranch(5, 0); #2; checkOutput("perf_s2", 1'b1);
    nextCycle(); doLoad(6);      #2; checkOutput("perf_lw2", 1'b0);
    nextCycle(); doAlu(6, 0, 7); #2; checkOutput("perf_s3", 1'b1);
    nextCycle(); doIdle();       #2;
    n_vec++;
    assert (stall_cycles === 32'd3) else begin
      n_miss++;
      $error("[TB] FAIL perf_three count actual=%0d expected=3", stall_cycles);
    end
    rst = 1'b1; #1;
    n_vec++;
    assert (stall_cycles === 32'd0) else begin
      n_miss++;
      $error("[TB] FAIL perf_rst count actual=%0d expected=0", stall_cycles);
    end
    rst = 1'b0;
`endif

    nextCycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
